paddle_cmd_rx: RTL and testbench

Receive end of the inter-board paddle link: deserializes 8N1 UART frames from the remote board's tilt sender and decodes command bytes into paddle up/down levels. Sits between the GPIO input pin and the paddle module's second-player button inputs. Includes line synchronization, start-bit glitch rejection, stop-bit checking, and a link-loss timeout that releases the paddle.

---
 rtl/paddle_cmd_rx.sv | 201 ++++++++++++++++++++
 tb/tb_paddle_cmd_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_cmd_rx.sv
// paddle_cmd_rx: UART receiver for the inter-board paddle link. Decodes command bytes into
// paddle up/down levels and drops the paddle when the link times out.
// Define PADDLE_CMD_PARITY_EN to expect an even parity bit (8E1 frame) instead of 8N1.
module paddle_cmd_rx #(
  parameter int CLKS_PER_BIT   = 87,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx_serial,
  output logic       o_up,
  output logic       o_down,
  output logic       o_cmd_valid,
  output logic [7:0] o_cmd_byte,
  output logic       o_frame_err,
  output logic       o_bad_cmd,
  output logic       o_link_ok
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_DOWN = 8'h00;
  localparam logic [7:0] CMD_UP   = 8'h01;
  localparam logic [7:0] CMD_HOLD = 8'h02;

`ifdef PADDLE_CMD_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [1:0]       sync_reg;
  logic             line_prev_reg;
  logic             rx_line;

  state_t           state_reg;
  logic [CNT_W-1:0] clk_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             frame_done_reg;
  logic             frame_ok_reg;
  logic             parity_ok;
`ifdef PADDLE_CMD_PARITY_EN
  logic             parity_reg;
`endif

  logic [TO_W-1:0]  timeout_cnt_reg;
  logic             known_cmd;

  assign rx_line = sync_reg[1];

  // Line synchronizer; flops reset to the idle (high) level so release never fakes a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg      <= 2'b11;
      line_prev_reg <= 1'b1;
    end else begin
      sync_reg      <= {sync_reg[0], i_rx_serial};
      line_prev_reg <= sync_reg[1];
    end
  end

`ifdef PADDLE_CMD_PARITY_EN
  assign parity_ok = ~(^{shift_reg, parity_reg});
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM. frame_done_reg/frame_ok_reg flag the stop-bit sample to the decode stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      clk_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      frame_done_reg <= 1'b0;
      frame_ok_reg   <= 1'b0;
`ifdef PADDLE_CMD_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      frame_done_reg <= 1'b0;
      frame_ok_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          clk_cnt_reg <= '0;
          bit_idx_reg <= '0;
          if (line_prev_reg && !rx_line) begin
            state_reg <= S_START;
          end
        end
        S_START: begin
          if (clk_cnt_reg == HALF_LAST) begin
            clk_cnt_reg <= '0;
            // A line already back high at mid-start was a glitch, not a frame.
            state_reg   <= rx_line ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            shift_reg   <= {rx_line, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef PADDLE_CMD_PARITY_EN
              state_reg <= S_PARITY;
`else
              state_reg <= S_STOP;
`endif
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
`ifdef PADDLE_CMD_PARITY_EN
        S_PARITY: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            parity_reg  <= rx_line;
            state_reg   <= S_STOP;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg    <= '0;
            frame_done_reg <= 1'b1;
            frame_ok_reg   <= rx_line && parity_ok;
            // Back to IDLE at mid-stop so a back-to-back start edge is not missed.
            state_reg      <= S_IDLE;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    known_cmd = 1'b0;
    if (frame_done_reg && frame_ok_reg) begin
      known_cmd = (shift_reg == CMD_DOWN) || (shift_reg == CMD_UP) || (shift_reg == CMD_HOLD);
    end
  end

  // Decode and link supervision; shift_reg stays stable for a full bit after the stop sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_up            <= 1'b0;
      o_down          <= 1'b0;
      o_cmd_valid     <= 1'b0;
      o_cmd_byte      <= 8'h00;
      o_frame_err     <= 1'b0;
      o_bad_cmd       <= 1'b0;
      o_link_ok       <= 1'b0;
      timeout_cnt_reg <= '0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_bad_cmd   <= 1'b0;

      if (frame_done_reg) begin
        if (frame_ok_reg) begin
          o_cmd_valid <= 1'b1;
          o_cmd_byte  <= shift_reg;
          o_bad_cmd   <= !known_cmd;
        end else begin
          o_frame_err <= 1'b1;
        end
      end

      // A known command takes priority over a timeout expiring on the same edge.
      if (known_cmd) begin
        timeout_cnt_reg <= '0;
        o_link_ok       <= 1'b1;
        o_up            <= (shift_reg == CMD_UP);
        o_down          <= (shift_reg == CMD_DOWN);
      end else if (timeout_cnt_reg != TO_MAX) begin
        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        if (timeout_cnt_reg == TO_LAST) begin
          o_link_ok <= 1'b0;
          o_up      <= 1'b0;
          o_down    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_cmd_rx.sv
// Directed testbench for paddle_cmd_rx (CLKS_PER_BIT=8, TIMEOUT_CYCLES=2000).
// Honours PADDLE_CMD_PARITY_EN to drive 8E1 frames and exercise the parity error path.
module tb_paddle_cmd_rx;

  localparam int C = 8;
  localparam int T = 2000;
`ifdef PADDLE_CMD_PARITY_EN
  localparam int LAT = 2 + 1 + (C - 1) / 2 + 9 * C + 1 + C;
`else
  localparam int LAT = 2 + 1 + (C - 1) / 2 + 9 * C + 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_rx_serial = 1'b1;
  logic       o_up, o_down, o_cmd_valid, o_frame_err, o_bad_cmd, o_link_ok;
  logic [7:0] o_cmd_byte;

  int cyc = 0;
  int cnt_valid = 0, cnt_ferr = 0, cnt_bad = 0, last_valid_cyc = -1;
  int passed = 0, total = 0;

  paddle_cmd_rx #(.CLKS_PER_BIT(C), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .i_rx_serial(i_rx_serial),
    .o_up(o_up), .o_down(o_down), .o_cmd_valid(o_cmd_valid), .o_cmd_byte(o_cmd_byte),
    .o_frame_err(o_frame_err), .o_bad_cmd(o_bad_cmd), .o_link_ok(o_link_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_cmd_valid) begin
      cnt_valid++;
      last_valid_cyc = cyc;
    end
    if (o_frame_err) cnt_ferr++;
    if (o_bad_cmd) cnt_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_rx_serial = b;
    tick(C);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
    $display("tx byte=%02h stop=%b par_bad=%b at cyc %0d", b, stop_bit, par_bad, cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PADDLE_CMD_PARITY_EN
    drive_bit((^b) ^ par_bad);
`endif
    drive_bit(stop_bit);
    i_rx_serial = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    i_rx_serial = 1'b1;
    tick(3);
    total++; if (o_up !== 1'b0) $display("FAIL reset_up: got %b want 0", o_up); else passed++;
    total++; if (o_down !== 1'b0) $display("FAIL reset_down: got %b want 0", o_down); else passed++;
    total++; if (o_cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_cmd_valid); else passed++;
    total++; if (o_cmd_byte !== 8'h00) $display("FAIL reset_byte: got %02h want 00", o_cmd_byte); else passed++;
    total++; if (o_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", o_frame_err); else passed++;
    total++; if (o_bad_cmd !== 1'b0) $display("FAIL reset_bad: got %b want 0", o_bad_cmd); else passed++;
    total++; if (o_link_ok !== 1'b0) $display("FAIL reset_link: got %b want 0", o_link_ok); else passed++;
    reset_n = 1'b1;
    tick(20);
    total++; if (o_link_ok !== 1'b0) $display("FAIL link_before_cmd: got %b want 0", o_link_ok); else passed++;
    total++; if (cnt_valid + cnt_ferr + cnt_bad !== 0)
      $display("FAIL idle_pulses: got %0d pulses want 0", cnt_valid + cnt_ferr + cnt_bad); else passed++;
  endtask

  task automatic test_cmd_up;
    int v0, start;
    v0 = cnt_valid;
    start = cyc;
    send_frame(8'h01, 1'b1, 1'b0);
    total++; if (cnt_valid !== v0 + 1) $display("FAIL up_valid_count: got %0d want %0d", cnt_valid - v0, 1); else passed++;
    total++; if (last_valid_cyc !== start + LAT)
      $display("FAIL up_latency: got %0d want %0d", last_valid_cyc - start, LAT); else passed++;
    total++; if (o_cmd_byte !== 8'h01) $display("FAIL up_byte: got %02h want 01", o_cmd_byte); else passed++;
    total++; if (o_up !== 1'b1) $display("FAIL up_up: got %b want 1", o_up); else passed++;
    total++; if (o_down !== 1'b0) $display("FAIL up_down: got %b want 0", o_down); else passed++;
    total++; if (o_link_ok !== 1'b1) $display("FAIL up_link: got %b want 1", o_link_ok); else passed++;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = cnt_valid;
    send_frame(8'h00, 1'b1, 1'b0);
    total++; if (o_down !== 1'b1) $display("FAIL b2b_down_first: got %b want 1", o_down); else passed++;
    total++; if (o_up !== 1'b0) $display("FAIL b2b_up_first: got %b want 0", o_up); else passed++;
    send_frame(8'h02, 1'b1, 1'b0);
    total++; if (cnt_valid !== v0 + 2) $display("FAIL b2b_valid_count: got %0d want 2", cnt_valid - v0); else passed++;
    total++; if (o_cmd_byte !== 8'h02) $display("FAIL b2b_byte: got %02h want 02", o_cmd_byte); else passed++;
    total++; if (o_up !== 1'b0 || o_down !== 1'b0)
      $display("FAIL b2b_hold: got up=%b down=%b want 0 0", o_up, o_down); else passed++;
  endtask

  task automatic test_frame_err;
    int v0, f0;
    send_frame(8'h01, 1'b1, 1'b0);
    v0 = cnt_valid;
    f0 = cnt_ferr;
    send_frame(8'h00, 1'b0, 1'b0);
    tick(2);
    total++; if (cnt_ferr !== f0 + 1) $display("FAIL ferr_count: got %0d want 1", cnt_ferr - f0); else passed++;
    total++; if (cnt_valid !== v0) $display("FAIL ferr_no_valid: got %0d want 0", cnt_valid - v0); else passed++;
    total++; if (o_cmd_byte !== 8'h01) $display("FAIL ferr_byte_held: got %02h want 01", o_cmd_byte); else passed++;
    total++; if (o_up !== 1'b1 || o_down !== 1'b0)
      $display("FAIL ferr_paddle_held: got up=%b down=%b want 1 0", o_up, o_down); else passed++;
  endtask

  task automatic test_glitch;
    int v0, f0, b0, start;
    tick(4 * C);
    v0 = cnt_valid; f0 = cnt_ferr; b0 = cnt_bad;
    i_rx_serial = 1'b0;
    tick(2);
    i_rx_serial = 1'b1;
    tick(3);
    total++; if (cnt_valid + cnt_ferr + cnt_bad !== v0 + f0 + b0)
      $display("FAIL glitch_pulses: got %0d pulses want 0", cnt_valid + cnt_ferr + cnt_bad - v0 - f0 - b0); else passed++;
    start = cyc;
    send_frame(8'h02, 1'b1, 1'b0);
    total++; if (last_valid_cyc !== start + LAT)
      $display("FAIL glitch_recover_latency: got %0d want %0d", last_valid_cyc - start, LAT); else passed++;
    total++; if (cnt_valid !== v0 + 1 || cnt_ferr !== f0)
      $display("FAIL glitch_recover_frame: got valid=%0d ferr=%0d want 1 0", cnt_valid - v0, cnt_ferr - f0); else passed++;
  endtask

  task automatic test_bad_cmd_timeout;
    int b0, u;
    send_frame(8'h01, 1'b1, 1'b0);
    u = last_valid_cyc;
    total++; if (o_up !== 1'b1) $display("FAIL to_up_set: got %b want 1", o_up); else passed++;
    b0 = cnt_bad;
    send_frame(8'h55, 1'b1, 1'b0);
    total++; if (cnt_bad !== b0 + 1) $display("FAIL bad_cmd_count: got %0d want 1", cnt_bad - b0); else passed++;
    total++; if (o_cmd_byte !== 8'h55) $display("FAIL bad_cmd_byte: got %02h want 55", o_cmd_byte); else passed++;
    total++; if (o_up !== 1'b1 || o_down !== 1'b0)
      $display("FAIL bad_cmd_paddle: got up=%b down=%b want 1 0", o_up, o_down); else passed++;
    while (cyc < u + T - 1) @(negedge clk);
    total++; if (o_link_ok !== 1'b1 || o_up !== 1'b1)
      $display("FAIL to_before_expiry: got link=%b up=%b want 1 1", o_link_ok, o_up); else passed++;
    @(negedge clk);
    total++; if (o_link_ok !== 1'b0) $display("FAIL to_link_drop: got %b want 0", o_link_ok); else passed++;
    total++; if (o_up !== 1'b0 || o_down !== 1'b0)
      $display("FAIL to_paddle_release: got up=%b down=%b want 0 0", o_up, o_down); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, b0;
    send_frame(8'h01, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b1 : 1'b0);
    i_rx_serial = 1'b0;
    tick(3);
    reset_n = 1'b0;
    i_rx_serial = 1'b1;
    tick(1);
    total++; if (o_up !== 1'b0 || o_link_ok !== 1'b0)
      $display("FAIL midrst_outputs: got up=%b link=%b want 0 0", o_up, o_link_ok); else passed++;
    total++; if (o_cmd_byte !== 8'h00) $display("FAIL midrst_byte: got %02h want 00", o_cmd_byte); else passed++;
    tick(2);
    reset_n = 1'b1;
    v0 = cnt_valid; f0 = cnt_ferr; b0 = cnt_bad;
    tick(20 * C);
    total++; if (cnt_valid + cnt_ferr + cnt_bad !== v0 + f0 + b0)
      $display("FAIL midrst_no_output: got %0d pulses want 0", cnt_valid + cnt_ferr + cnt_bad - v0 - f0 - b0); else passed++;
    send_frame(8'h00, 1'b1, 1'b0);
    total++; if (o_down !== 1'b1 || o_up !== 1'b0)
      $display("FAIL midrst_new_frame: got up=%b down=%b want 0 1", o_up, o_down); else passed++;
    total++; if (cnt_valid !== v0 + 1) $display("FAIL midrst_valid_count: got %0d want 1", cnt_valid - v0); else passed++;
  endtask

`ifdef PADDLE_CMD_PARITY_EN
  task automatic test_parity;
    int v0, f0;
    v0 = cnt_valid;
    f0 = cnt_ferr;
    send_frame(8'h01, 1'b1, 1'b1);
    tick(2);
    total++; if (cnt_ferr !== f0 + 1) $display("FAIL parity_ferr: got %0d want 1", cnt_ferr - f0); else passed++;
    total++; if (cnt_valid !== v0) $display("FAIL parity_no_valid: got %0d want 0", cnt_valid - v0); else passed++;
    total++; if (o_down !== 1'b1 || o_cmd_byte !== 8'h00)
      $display("FAIL parity_held: got down=%b byte=%02h want 1 00", o_down, o_cmd_byte); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_up();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_bad_cmd_timeout();
    test_reset_mid_frame();
`ifdef PADDLE_CMD_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
